// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard scoreboard.
// Provides the per-stage entry record, the forward-select width helper and the
// register-file select constant. REG_W_MAX bounds the REG_ADDR_W parameter.
package hazard_pkg;
   localparam int REG_W_MAX   = 8;
   localparam int FWD_REGFILE = 0;
   typedef struct packed {
      logic                 v;
      logic [REG_W_MAX-1:0] dst;
      logic                 is_load;
   } entry_t;
   function automatic int fwd_sel_w(input int n);
      return n < 1 ? 1 : $clog2(n + 1);
   endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-stage bundle between the CPU decode logic and the scoreboard.
// master = decode side (drives id_*, flush; receives stall, selects, stage_valid, stall_cycles).
// slave  = scoreboard side.
interface hazard_scoreboard_if #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_STAGES = 3,
   parameter int CNT_W      = 32
);
   import hazard_pkg::*;
   localparam int SW = fwd_sel_w(NUM_STAGES);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_rs_used;
   logic                  id_rt_used;
   logic [REG_ADDR_W-1:0] id_dst;
   logic                  id_we;
   logic                  id_is_load;
   logic                  flush;
   logic                  stall;
   logic [SW-1:0]         fwd_rs_sel;
   logic [SW-1:0]         fwd_rt_sel;
   logic [NUM_STAGES-1:0] stage_valid;
   logic [CNT_W-1:0]      stall_cycles;
   modport master (
      output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dst, id_we, id_is_load, flush,
      input  stall, fwd_rs_sel, fwd_rt_sel, stage_valid, stall_cycles
   );
   modport slave (
      input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dst, id_we, id_is_load, flush,
      output stall, fwd_rs_sel, fwd_rt_sel, stage_valid, stall_cycles
   );
endinterface

// File: rtl/hazard_scoreboard_fwd_match.sv
// fwd_match: priority encoder picking the youngest tracked stage that writes operand r.
// Ports: stg (entries, index 0 = EXE), r/used (operand), sel (0 = regfile, k = stage k),
// is_load (winning producer is a load).
module fwd_match
   import hazard_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int SW         = fwd_sel_w(NUM_STAGES)
) (
   input  entry_t [NUM_STAGES-1:0] stg,
   input  logic [REG_W_MAX-1:0]    r,
   input  logic                    used,
   output logic [SW-1:0]           sel,
   output logic                    is_load
);
   always_comb begin
      sel     = SW'(FWD_REGFILE);
      is_load = 1'b0;
      // scan oldest to youngest so the youngest match is the one left standing
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         if (stg[k].v && stg[k].dst == r && r != '0 && used) begin
            sel     = SW'(k + 1);
            is_load = stg[k].is_load;
         end
      end
   end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks post-decode writers and produces decode stall and forward selects.
// Ports: clk, rst (async active-low), bus (hazard_scoreboard_if.slave).
// HAZARD_SCOREBOARD_FWD_EN defined: forwarding with load-use stall only.
// Undefined: selects tied to regfile, stall on any pending writer until it retires.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_STAGES = 3,
   parameter int LOAD_READY = 2,
   parameter int CNT_W      = 32
) (
   input logic              clk,
   input logic              rst,
   hazard_scoreboard_if.slave bus
);
   localparam int SW = fwd_sel_w(NUM_STAGES);
   entry_t [NUM_STAGES-1:0] stg_q, stg_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [SW-1:0]           rs_sel, rt_sel;
   logic                    rs_ld, rt_ld, load_use, hazard, stall, enter;
   fwd_match #(.NUM_STAGES(NUM_STAGES), .SW(SW)) u_rs (
      .stg(stg_q), .r(REG_W_MAX'(bus.id_rs)), .used(bus.id_rs_used), .sel(rs_sel), .is_load(rs_ld)
   );
   fwd_match #(.NUM_STAGES(NUM_STAGES), .SW(SW)) u_rt (
      .stg(stg_q), .r(REG_W_MAX'(bus.id_rt)), .used(bus.id_rt_used), .sel(rt_sel), .is_load(rt_ld)
   );
   always_comb begin
      load_use = (rs_ld & (int'(rs_sel) < LOAD_READY)) | (rt_ld & (int'(rt_sel) < LOAD_READY));
`ifdef HAZARD_SCOREBOARD_FWD_EN
      hazard = load_use;
`else
      hazard = (rs_sel != SW'(FWD_REGFILE)) | (rt_sel != SW'(FWD_REGFILE)) | load_use;
`endif
      stall = bus.id_valid & ~bus.flush & hazard;
      enter = bus.id_valid & ~stall & ~bus.flush & bus.id_we & (bus.id_dst != '0);
      stg_d[0] = enter ? entry_t'{v: 1'b1, dst: REG_W_MAX'(bus.id_dst), is_load: bus.id_is_load} : entry_t'('0);
      for (int k = 1; k < NUM_STAGES; k++) stg_d[k] = stg_q[k-1];
      cnt_d = (stall & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stg_q <= '0;
         cnt_q <= '0;
      end else begin
         stg_q <= stg_d;
         cnt_q <= cnt_d;
      end
   end
   always_comb begin
      for (int k = 0; k < NUM_STAGES; k++) bus.stage_valid[k] = stg_q[k].v;
   end
   assign bus.stall        = stall;
   assign bus.stall_cycles = cnt_q;
`ifdef HAZARD_SCOREBOARD_FWD_EN
   assign bus.fwd_rs_sel = rs_sel;
   assign bus.fwd_rt_sel = rt_sel;
`else
   assign bus.fwd_rs_sel = SW'(FWD_REGFILE);
   assign bus.fwd_rt_sel = SW'(FWD_REGFILE);
`endif
endmodule
